// File: rtl/mul_result_stage_pkg.sv
// Shared constants and encodings for the multiplier result stage.
package mul_result_stage_pkg;

  localparam int XLEN     = 32;
  localparam int CS_WIDTH = 2 * XLEN + 4;
  localparam int SPLIT    = 34;
  localparam int TAG_W    = 5;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // Only plain MUL returns the low product word; all high variants share the upper word.
  function automatic logic sel_low_word(mul_op_e op);
    return op == MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/mul_result_stage_if.sv
// Upstream carry-save handshake and downstream result handshake of the result stage.
interface mul_result_stage_if #(
  parameter int N    = mul_result_stage_pkg::CS_WIDTH,
  parameter int XLEN = mul_result_stage_pkg::XLEN
);
  logic            valid_i;
  logic            ready_o;
  logic [N-1:0]    opdata1;
  logic [N-1:0]    opdata2;
  logic [1:0]      mul_op;
  logic [4:0]      rd_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_o;

  modport slave (
    input  valid_i, opdata1, opdata2, mul_op, rd_i, ready_i,
    output ready_o, valid_o, result, rd_o
  );

  modport master (
    output valid_i, opdata1, opdata2, mul_op, rd_i, ready_i,
    input  ready_o, valid_o, result, rd_o
  );
endinterface

// File: rtl/mul_split_adder.sv
// W-bit adder with carry-in and carry-out, used for both halves of the split resolve.
module mul_split_adder #(
  parameter int W = 34
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/mul_result_stage.sv
// Two-stage carry-save resolve: S1 adds the low 34 bits, S2 adds the upper bits with the
// registered carry and selects the product word for the requested multiply variant.
module mul_result_stage #(
  parameter int N    = mul_result_stage_pkg::CS_WIDTH,
  parameter int XLEN = mul_result_stage_pkg::XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  mul_result_stage_if.slave   bus
);
  import mul_result_stage_pkg::*;

  localparam int HI_W = N - SPLIT;

  // Low-half add on the incoming carry-save pair
  logic [SPLIT-1:0] lo_sum;
  logic             lo_carry;

  mul_split_adder #(.W(SPLIT)) u_lo_add (
    .a_i   (bus.opdata1[SPLIT-1:0]),
    .b_i   (bus.opdata2[SPLIT-1:0]),
    .c_i   (1'b0),
    .sum_o (lo_sum),
    .c_o   (lo_carry)
  );

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [SPLIT-3:0]  s1_lo_q,    s1_lo_d;
  logic [1:0]        s1_mid_q,   s1_mid_d;
  logic              s1_c_q,     s1_c_d;
  logic [HI_W-1:0]   s1_hi1_q,   s1_hi1_d;
  logic [HI_W-1:0]   s1_hi2_q,   s1_hi2_d;
  mul_op_e           s1_op_q,    s1_op_d;
  logic [TAG_W-1:0]  s1_rd_q,    s1_rd_d;

  // Stage 2 registers
  logic              s2_valid_q,  s2_valid_d;
  logic [XLEN-1:0]   s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_rd_q,     s2_rd_d;

  // High-half add from the registered upper vectors and low carry
  logic [HI_W-1:0] hi_sum;
  logic            unused_hi_carry;
  logic [N-1:0]    full_sum;
  logic            unused_sum_bits;

  mul_split_adder #(.W(HI_W)) u_hi_add (
    .a_i   (s1_hi1_q),
    .b_i   (s1_hi2_q),
    .c_i   (s1_c_q),
    .sum_o (hi_sum),
    .c_o   (unused_hi_carry)
  );

  assign full_sum        = {hi_sum, s1_mid_q, s1_lo_q};
  assign unused_sum_bits = ^{unused_hi_carry, full_sum[N-1:2*XLEN]};

  // Handshake: each stage moves when its successor is empty or draining this cycle
  logic s2_advance;
  logic s1_advance;
  logic accept;
  logic s2_load;

  assign s2_advance = !s2_valid_q || bus.ready_i;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign accept     = bus.valid_i && s1_advance;
  assign s2_load    = s1_valid_q && s2_advance;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_advance) s1_valid_d = bus.valid_i;
      if (s2_advance) s2_valid_d = s1_valid_q;
    end
  end

  always_comb begin
    s1_lo_d  = s1_lo_q;
    s1_mid_d = s1_mid_q;
    s1_c_d   = s1_c_q;
    s1_hi1_d = s1_hi1_q;
    s1_hi2_d = s1_hi2_q;
    s1_op_d  = s1_op_q;
    s1_rd_d  = s1_rd_q;
    if (accept) begin
      s1_lo_d  = lo_sum[SPLIT-3:0];
      s1_mid_d = lo_sum[SPLIT-1:SPLIT-2];
      s1_c_d   = lo_carry;
      s1_hi1_d = bus.opdata1[N-1:SPLIT];
      s1_hi2_d = bus.opdata2[N-1:SPLIT];
      s1_op_d  = mul_op_e'(bus.mul_op);
      s1_rd_d  = bus.rd_i;
    end
  end

  always_comb begin
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;
    if (s2_load) begin
      s2_result_d = sel_low_word(s1_op_q) ? full_sum[XLEN-1:0]
                                          : full_sum[2*XLEN-1:XLEN];
      s2_rd_d     = s1_rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
    end
  end

  // Stage 1 payload is qualified by s1_valid_q, so it carries no reset
  always_ff @(posedge clk) begin
    s1_lo_q  <= s1_lo_d;
    s1_mid_q <= s1_mid_d;
    s1_c_q   <= s1_c_d;
    s1_hi1_q <= s1_hi1_d;
    s1_hi2_q <= s1_hi2_d;
    s1_op_q  <= s1_op_d;
    s1_rd_q  <= s1_rd_d;
  end

  assign bus.ready_o = s1_advance;
  assign bus.valid_o = s2_valid_q;
  assign bus.result  = s2_result_q;
  assign bus.rd_o    = s2_rd_q;

endmodule

// File: tb/tb_mul_result_stage.sv
// Randomized and directed checks of mul_result_stage against a queue-based reference model.
module tb_mul_result_stage;
  import mul_result_stage_pkg::*;

  localparam int NW = 68;
  localparam int XW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  mul_result_stage_if #(.N(NW), .XLEN(XW)) bus ();

  mul_result_stage #(.N(NW), .XLEN(XW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          age;
  } item_t;

  item_t pipe_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    dut_out = 0;
  int    ready_low_seen = 0;
  bit    last_accept = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Product word straight from the full modular sum
  function automatic logic [31:0] ref_result(input logic [67:0] a, input logic [67:0] b,
                                             input logic [1:0] op);
    logic [67:0] s;
    s = a + b;
    return (op == 2'b00) ? s[31:0] : s[63:32];
  endfunction

  function automatic logic [67:0] rand68();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    if ($urandom_range(3, 0) == 0) r[33:0] = '1;
    return r[67:0];
  endfunction

  task automatic rand_inputs();
    bus.opdata1 = rand68();
    bus.opdata2 = rand68();
    bus.mul_op  = 2'($urandom_range(3, 0));
    bus.rd_i    = 5'($urandom_range(31, 0));
  endtask

  // One clock cycle: called at a falling edge with inputs already applied
  task automatic cycle();
    logic  exp_valid;
    logic  exp_ready;
    item_t it;
    #1;
    exp_valid = (pipe_q.size() > 0) && (pipe_q[0].age >= 1);
    exp_ready = (pipe_q.size() < 2) || bus.ready_i;
    check_eq("ready_o", 64'(bus.ready_o), 64'(exp_ready));
    check_eq("valid_o", 64'(bus.valid_o), 64'(exp_valid));
    if (exp_valid) begin
      check_eq("result", 64'(bus.result), 64'(pipe_q[0].res));
      check_eq("rd_o", 64'(bus.rd_o), 64'(pipe_q[0].rd));
    end
    if (!bus.ready_o) ready_low_seen++;
    if (bus.valid_o && bus.ready_i) dut_out++;
    if (exp_valid && bus.ready_i) void'(pipe_q.pop_front());
    foreach (pipe_q[i]) pipe_q[i].age++;
    last_accept = 1'b0;
    if (flush) begin
      pipe_q.delete();
    end else if (bus.valid_i && exp_ready) begin
      it.res = ref_result(bus.opdata1, bus.opdata2, bus.mul_op);
      it.rd  = bus.rd_i;
      it.age = 0;
      pipe_q.push_back(it);
      last_accept = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [67:0] a, input logic [67:0] b,
                          input logic [1:0] op, input logic [4:0] rd, input logic [31:0] exp_res);
    bus.opdata1 = a;
    bus.opdata2 = b;
    bus.mul_op  = op;
    bus.rd_i    = rd;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    cycle();
    bus.valid_i = 1'b0;
    cycle();
    #1;
    check_eq({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
    check_eq(tag, 64'(bus.result), 64'(exp_res));
    check_eq({tag, "_rd"}, 64'(bus.rd_o), 64'(rd));
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int out0;
    int c;

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.mul_op  = 2'b00;
    bus.rd_i    = '0;

    #3;
    check_eq("rst_valid", 64'(bus.valid_o), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_rd", 64'(bus.rd_o), 64'd0);
    check_eq("rst_ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed("mul_basic", 68'd42, 68'd0, 2'b00, 5'd5, 32'h0000_002A);
    directed("mulhu_hi", 68'hFFFF_FFFE_0000_0000, 68'd1, 2'b11, 5'd9, 32'hFFFF_FFFE);
    directed("mul_lo", 68'hFFFF_FFFE_0000_0000, 68'd1, 2'b00, 5'd10, 32'h0000_0001);
    directed("split_carry", 68'h3_FFFF_FFFF, 68'd1, 2'b01, 5'd17, 32'h0000_0004);
    directed("split_discard", 68'h3_FFFF_FFFF, 68'h3_0000_0000_0000_0001, 2'b01, 5'd18,
             32'h0000_0004);

    // Backpressure: four back-to-back inputs, downstream stalled in cycles 3-6
    sent = 0;
    out0 = dut_out;
    c = 0;
    ready_low_seen = 0;
    rand_inputs();
    while (sent < 4 && c < 30) begin
      bus.ready_i = !(c >= 3 && c <= 6);
      bus.valid_i = 1'b1;
      cycle();
      if (last_accept) begin
        sent++;
        rand_inputs();
      end
      c++;
    end
    bus.valid_i = 1'b0;
    while ((dut_out - out0) < 4 && c < 40) begin
      bus.ready_i = !(c >= 3 && c <= 6);
      cycle();
      c++;
    end
    check_eq("bp_sent", 64'(sent), 64'd4);
    check_eq("bp_count", 64'(dut_out - out0), 64'd4);
    check_eq("bp_ready_drop", 64'(ready_low_seen > 0), 64'd1);
    bus.ready_i = 1'b1;
    cycle();

    // Flush with both stages full and a simultaneous offer
    bus.ready_i = 1'b0;
    sent = 0;
    c = 0;
    while (sent < 2 && c < 10) begin
      rand_inputs();
      bus.valid_i = 1'b1;
      cycle();
      if (last_accept) sent++;
      c++;
    end
    #1;
    check_eq("flush_full_ready", 64'(bus.ready_o), 64'd0);
    rand_inputs();
    flush = 1'b1;
    bus.valid_i = 1'b1;
    cycle();
    flush = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    check_eq("flush_valid", 64'(bus.valid_o), 64'd0);
    check_eq("flush_ready", 64'(bus.ready_o), 64'd1);
    bus.ready_i = 1'b1;
    cycle();

    // Mid-stream asynchronous reset
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      bus.valid_i = 1'b1;
      bus.ready_i = (i != 3);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 64'(bus.valid_o), 64'd0);
    check_eq("rst_mid_result", 64'(bus.result), 64'd0);
    check_eq("rst_mid_rd", 64'(bus.rd_o), 64'd0);
    check_eq("rst_mid_ready", 64'(bus.ready_o), 64'd1);
    pipe_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_i = 1'b0;
    cycle();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      bus.valid_i = ($urandom_range(9, 0) < 7);
      bus.ready_i = ($urandom_range(9, 0) < 7);
      flush       = ($urandom_range(49, 0) == 0);
      cycle();
    end
    flush = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_result_stage.md
MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

Interface
REQ-001 Parameter N, default 68, SHALL set the width of the carry-save input pair.
REQ-002 Parameter XLEN, default 32, SHALL set the result width; N >= 2*XLEN+2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 valid_i  input  1  upstream carry-save pair valid.
REQ-007 ready_o  output  1  stage can accept opdata this cycle.
REQ-008 opdata1  input  N  carry-save sum vector from the compressor tree.
REQ-009 opdata2  input  N  carry-save carry vector from the compressor tree.
REQ-010 mul_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-011 rd_i  input  5  destination register tag, carried alongside the data.
REQ-012 valid_o  output  1  result valid.
REQ-013 ready_i  input  1  downstream accepts the result.
REQ-014 result  output  XLEN  selected product word.
REQ-015 rd_o  output  5  tag for the result.

Function
REQ-016 Transfer on either side SHALL occur only when valid and ready are both high in the same cycle.
REQ-017 Pipeline SHALL have two register stages, S1 and S2; latency from input acceptance to valid_o SHALL be exactly 2 cycles when ready_i is held high.
REQ-018 S1 SHALL compute low half L = opdata1[33:0] + opdata2[33:0]. S1 SHALL register L[31:0], the carry out of bit 33, L[33:32], opdata1[N-1:34], opdata2[N-1:34], mul_op and rd_i.
REQ-019 S2 SHALL compute the high half from the registered upper bits plus the registered low carry. The full sum SHALL equal (opdata1+opdata2) mod 2^N.
REQ-020 result SHALL be sum[XLEN-1:0] for MUL and sum[2*XLEN-1:XLEN] for MULH/MULHSU/MULHU. Bits at and above 2*XLEN SHALL be discarded.
REQ-021 Each stage SHALL advance when the next stage is empty or is transferring out in the same cycle. Otherwise it SHALL hold its contents unchanged.
REQ-022 ready_o SHALL be !s1_valid || s2_advance, combinational with no dependence on valid_i.
REQ-023 The pipeline SHALL sustain one result per cycle with ready_i constantly high.
REQ-024 With ready_i low, result, rd_o and valid_o SHALL remain stable until the transfer completes.
REQ-025 flush SHALL clear s1_valid and s2_valid at the next edge and SHALL override any simultaneous acceptance. ready_o SHALL be 1 in the cycle after a flush.
REQ-026 Data registers SHALL load only on stage advance; valid bits alone SHALL define occupancy.

Reset
REQ-027 On rst_n low, s1_valid, s2_valid and valid_o SHALL clear immediately, asynchronously. Reset mid-operation SHALL discard in-flight results.
REQ-028 On rst_n low, result and rd_o SHALL read 0 and ready_o SHALL read 1.
REQ-029 Data registers need no reset beyond result and rd_o.

Structure
REQ-030 The mul_op encodings, XLEN and the split point 34 SHALL live in the shared core package.
REQ-031 One sub-module, mul_split_adder (34-bit plus carry-in, carry-out), SHALL be instantiated for the low add. A parameterised instance SHALL be used for the high add.

Verification
REQ-032 Basic MUL: opdata1=42, opdata2=0, mul_op=00, rd_i=5, ready_i=1 -> valid_o 2 cycles later, result=0x0000002A, rd_o=5.
REQ-033 MULHU high word: opdata1=0xFFFFFFFE00000000, opdata2=1, mul_op=11 -> result=0xFFFFFFFE. The same input with mul_op=00 -> result=0x00000001.
REQ-034 Carry across split: opdata1=0x3FFFFFFFF, opdata2=1, mul_op=01 -> result=0x00000004. The input with opdata2=0x3_0000_0000_0000_0000 added SHALL give the same result (upper bits discarded).
REQ-035 Backpressure: 4 back-to-back inputs, ready_i low for cycles 3-6 -> ready_o drops once both stages are full. No result is lost or duplicated, and outputs arrive in order and stay stable while stalled.
REQ-036 Flush and reset: flush asserted together with valid_i while both stages are full -> next cycle valid_o=0 and ready_o=1. rst_n pulsed low mid-stream -> valid_o=0 immediately, result=0.
